// File: rtl/street_light_pkg.sv
// Shared types and default parameters for the street light sequencer.
package street_light_pkg;

  typedef enum logic [1:0] {
    StDay     = 2'd0,
    StRampOn  = 2'd1,
    StNight   = 2'd2,
    StRampOff = 2'd3
  } state_e;

  localparam int unsigned TickDivDefault       = 200000;
  localparam int unsigned DebounceTicksDefault = 8;
  localparam int unsigned StaggerTicksDefault  = 2;
  localparam int unsigned NumLampsDefault      = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/street_light_sequencer_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen
  import street_light_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault
) (
  input  logic clk_in,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(TICK_DIV);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CntW'(TICK_DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntW'(TICK_DIV - 1));

endmodule

// File: rtl/street_light_sequencer.sv
// Dusk/dawn lamp sequencer: synchronised, debounced sensor drives a staggered
// thermometer ramp of lamp enables, with force_off/force_on overrides.
module street_light_sequencer
  import street_light_pkg::*;
#(
  parameter int unsigned TICK_DIV       = TickDivDefault,
  parameter int unsigned DEBOUNCE_TICKS = DebounceTicksDefault,
  parameter int unsigned STAGGER_TICKS  = StaggerTicksDefault,
  parameter int unsigned NUM_LAMPS      = NumLampsDefault
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 light_sensor,
  input  logic                 force_off,
  input  logic                 force_on,
  output logic [NUM_LAMPS-1:0] lamp_en,
  output logic                 night,
  output logic [1:0]           state,
  output logic                 busy
);

  localparam int unsigned DebW  = cnt_width(DEBOUNCE_TICKS);
  localparam int unsigned StagW = cnt_width(STAGGER_TICKS);

  logic                 tick;
  logic [1:0]           sync_q;
  logic [DebW-1:0]      deb_cnt_q;
  logic                 night_q;
  logic                 demand;
  state_e               state_q;
  logic [NUM_LAMPS-1:0] lamp_q;
  logic [StagW-1:0]     stag_q;
  logic [NUM_LAMPS-1:0] lamp_up;
  logic [NUM_LAMPS-1:0] lamp_dn;
  logic                 stag_done;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk_in(clk_in),
    .reset (reset),
    .tick  (tick)
  );

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      deb_cnt_q <= '0;
      night_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], light_sensor};
      if (tick) begin
        if (sync_q[1] == night_q) begin
          deb_cnt_q <= '0;
        end else if (deb_cnt_q == DebW'(DEBOUNCE_TICKS - 1)) begin
          deb_cnt_q <= '0;
          night_q   <= ~night_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + DebW'(1);
        end
      end
    end
  end

  assign demand    = ~force_off & (force_on | night_q);
  assign lamp_up   = {lamp_q[NUM_LAMPS-2:0], 1'b1};
  assign lamp_dn   = {1'b0, lamp_q[NUM_LAMPS-1:1]};
  assign stag_done = tick && (stag_q == StagW'(STAGGER_TICKS - 1));

  // Demand changes are tested before ticks so a coincident tick is dropped.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= StDay;
      lamp_q  <= '0;
      stag_q  <= '0;
    end else if (force_off) begin
      state_q <= StDay;
      lamp_q  <= '0;
      stag_q  <= '0;
    end else begin
      unique case (state_q)
        StDay: begin
          lamp_q <= '0;
          if (demand) begin
            state_q <= StRampOn;
            lamp_q  <= NUM_LAMPS'(1);
            stag_q  <= '0;
          end
        end
        StRampOn: begin
          if (!demand) begin
            state_q <= StRampOff;
            stag_q  <= '0;
          end else if (stag_done) begin
            stag_q <= '0;
            lamp_q <= lamp_up;
            if (&lamp_up) state_q <= StNight;
          end else if (tick) begin
            stag_q <= stag_q + StagW'(1);
          end
        end
        StNight: begin
          if (!demand) begin
            state_q <= StRampOff;
            lamp_q  <= {1'b0, {(NUM_LAMPS - 1){1'b1}}};
            stag_q  <= '0;
          end else begin
            lamp_q <= '1;
          end
        end
        StRampOff: begin
          if (demand) begin
            state_q <= StRampOn;
            stag_q  <= '0;
          end else if (stag_done) begin
            stag_q <= '0;
            lamp_q <= lamp_dn;
            if (lamp_dn == '0) state_q <= StDay;
          end else if (tick) begin
            stag_q <= stag_q + StagW'(1);
          end
        end
      endcase
    end
  end

  assign lamp_en = lamp_q;
  assign night   = night_q;
  assign state   = state_q;
  assign busy    = (state_q == StRampOn) || (state_q == StRampOff);

endmodule
